// File: rtl/pc_if.sv
// Handshake bundle between the fetch/branch logic and the program-counter unit.
// The master drives the PC decision inputs; the slave (pc_unit) returns PC state.
interface pc_if;
    logic        NextPCsrc;
    logic [31:0] ALURes;
    logic        Stall;
    logic        TrapClr;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        Trap;
    logic [31:0] TrapPC;
    logic [31:0] InstRet;

    modport master (
        output NextPCsrc, ALURes, Stall, TrapClr,
        input  PC, PCplus4, Trap, TrapPC, InstRet
    );

    modport slave (
        input  NextPCsrc, ALURes, Stall, TrapClr,
        output PC, PCplus4, Trap, TrapPC, InstRet
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with a RUN/TRAP state machine: sequential/branch updates, a
// misaligned-target trap, and a retired-instruction counter.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_if.slave     bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t      state_q;
    logic        trap_q;
    logic [31:0] pc_q;
    logic [31:0] trap_pc_q;
    logic [31:0] inst_ret_q;

    logic [31:0] eff_target_s;
    logic        misaligned_s;

    // Branch target with bit 0 forced low; a set bit 1 means the target is misaligned.
    always_comb begin
        eff_target_s = bus.ALURes & 32'hFFFF_FFFE;
        misaligned_s = bus.NextPCsrc & eff_target_s[1];
    end

    // State machine and all architectural state; Stall only matters in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            trap_q     <= 1'b0;
            pc_q       <= RESET_VECTOR;
            trap_pc_q  <= 32'h0000_0000;
            inst_ret_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.Stall) begin
                        state_q <= ST_RUN;
                    end else if (misaligned_s) begin
                        state_q   <= ST_TRAP;
                        trap_q    <= 1'b1;
                        trap_pc_q <= pc_q;
                    end else if (bus.NextPCsrc) begin
                        pc_q       <= eff_target_s;
                        inst_ret_q <= inst_ret_q + 32'd1;
                    end else begin
                        pc_q       <= pc_q + 32'd4;
                        inst_ret_q <= inst_ret_q + 32'd1;
                    end
                end
                ST_TRAP: begin
                    if (bus.TrapClr) begin
                        state_q <= ST_RUN;
                        trap_q  <= 1'b0;
                        pc_q    <= TRAP_VECTOR;
                    end else begin
                        state_q <= ST_TRAP;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC      = pc_q;
    assign bus.PCplus4 = pc_q + 32'd4;
    assign bus.Trap    = trap_q;
    assign bus.TrapPC  = trap_pc_q;
    assign bus.InstRet = inst_ret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_pc_unit;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    pc_if bus ();

    pc_unit #(.RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_tpc, m_ret;
    bit          m_trap;

    task automatic model_reset();
        m_pc = RST_VEC; m_tpc = 32'h0; m_ret = 32'h0; m_trap = 1'b0;
    endtask

    task automatic model_step(input bit src, input logic [31:0] alu, input bit st, input bit clr);
        logic [31:0] tgt;
        tgt = {alu[31:1], 1'b0};
        if (m_trap) begin
            if (clr) begin
                m_trap = 1'b0;
                m_pc   = TRAP_VEC;
            end
        end else if (!st) begin
            if (src && tgt[1]) begin
                m_trap = 1'b1;
                m_tpc  = m_pc;
            end else begin
                m_pc  = src ? tgt : m_pc + 32'd4;
                m_ret = m_ret + 32'd1;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the inputs the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step(bus.NextPCsrc, bus.ALURes, bus.Stall, bus.TrapClr);
    end

    always @(negedge rst_n) model_reset();

    // Single compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pc",      bus.PC,      m_pc);
            check("cyc_pcplus4", bus.PCplus4, m_pc + 32'd4);
            check("cyc_trap",    {31'd0, bus.Trap}, {31'd0, m_trap});
            check("cyc_trappc",  bus.TrapPC,  m_tpc);
            check("cyc_instret", bus.InstRet, m_ret);
        end
    end

    task automatic set_in(input bit src, input logic [31:0] alu, input bit st, input bit clr);
        bus.NextPCsrc = src; bus.ALURes = alu; bus.Stall = st; bus.TrapClr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_pc",      bus.PC,      32'h0000_0000);
        check("rst_trap",    {31'd0, bus.Trap}, 32'd0);
        check("rst_trappc",  bus.TrapPC,  32'h0000_0000);
        check("rst_instret", bus.InstRet, 32'h0000_0000);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Three sequential steps
        tick(); tick(); tick();
        check("seq3_pc",      bus.PC,      32'h0000_000C);
        check("seq3_instret", bus.InstRet, 32'd3);
        check("seq3_pcplus4", bus.PCplus4, 32'h0000_0010);

        // Jump with bit 0 cleared, then stalled jump
        set_in(1'b1, 32'h0000_0041, 1'b0, 1'b0); tick();
        check("jmp_pc",      bus.PC,      32'h0000_0040);
        check("jmp_instret", bus.InstRet, 32'd4);
        set_in(1'b1, 32'h0000_0080, 1'b1, 1'b0); tick();
        check("stall_pc",      bus.PC,      32'h0000_0040);
        check("stall_instret", bus.InstRet, 32'd4);

        // Misaligned target traps; held stimulus changes nothing
        set_in(1'b1, 32'h0000_0046, 1'b0, 1'b0); tick();
        check("trap_flag",    {31'd0, bus.Trap}, 32'd1);
        check("trap_trappc",  bus.TrapPC,  32'h0000_0040);
        check("trap_pc",      bus.PC,      32'h0000_0040);
        check("trap_instret", bus.InstRet, 32'd4);
        tick(); tick();
        check("trap_hold_pc",   bus.PC, 32'h0000_0040);
        check("trap_hold_flag", {31'd0, bus.Trap}, 32'd1);
        set_in(1'b0, 32'h0, 1'b1, 1'b1); tick();
        check("clr_flag",    {31'd0, bus.Trap}, 32'd0);
        check("clr_pc",      bus.PC,      32'h0000_0100);
        check("clr_instret", bus.InstRet, 32'd4);
        check("clr_trappc",  bus.TrapPC,  32'h0000_0040);

        // Wrap at top of address space
        set_in(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0); tick();
        check("wrap_pre_pc",      bus.PC,      32'hFFFF_FFFC);
        check("wrap_pre_pcplus4", bus.PCplus4, 32'h0000_0000);
        set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();
        check("wrap_pc",      bus.PC,      32'h0000_0000);
        check("wrap_instret", bus.InstRet, 32'd6);

        // TrapClr ignored in RUN
        set_in(1'b0, 32'h0, 1'b0, 1'b1); tick();
        check("clr_in_run_pc", bus.PC, 32'h0000_0004);

        // Asynchronous reset while in TRAP, visible before the next edge
        set_in(1'b1, 32'h0000_0002, 1'b0, 1'b0); tick();
        check("pre_rst_trap", {31'd0, bus.Trap}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pc",      bus.PC,      RST_VEC);
        check("arst_trap",    {31'd0, bus.Trap}, 32'd0);
        check("arst_instret", bus.InstRet, 32'd0);
        check("arst_trappc",  bus.TrapPC,  32'd0);
        set_in(1'b1, 32'h0000_0020, 1'b0, 1'b1);
        tick();
        check("arst_hold_pc", bus.PC, RST_VEC);
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();
        check("post_rst_pc", bus.PC, 32'h0000_0004);

        // Randomized run against the model
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 8'($urandom_range(0, 255))},
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1);
            tick();
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, PC value loaded when a trap is cleared.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 NextPCsrc  input  1  branch-unit decision; 1 = take ALURes target, 0 = sequential.
REQ-006 ALURes  input  32  branch/jump target computed by the ALU.
REQ-007 Stall  input  1  1 = hold PC and counter this cycle.
REQ-008 TrapClr  input  1  1 = leave TRAP state and redirect to TRAP_VECTOR.
REQ-009 PC  output  32  current program counter (registered).
REQ-010 PCplus4  output  32  PC + 4, combinational, modulo 2^32.
REQ-011 Trap  output  1  1 while in TRAP state (registered).
REQ-012 TrapPC  output  32  PC of the instruction that raised the misaligned-target trap.
REQ-013 InstRet  output  32  count of retired instructions, i.e. accepted PC updates.

Function
REQ-014 The FSM SHALL have two states, RUN and TRAP, with Trap = (state == TRAP).
REQ-015 Effective target SHALL be {ALURes[31:1], 1'b0}: bit 0 is always cleared.
REQ-016 Misaligned SHALL be (NextPCsrc == 1) and (effective target bit 1 == 1).
REQ-017 RUN, Stall=1: PC, InstRet, TrapPC and state SHALL hold. Stall has priority over NextPCsrc.
REQ-018 RUN, Stall=0, NextPCsrc=0: PC <= PC + 4 (mod 2^32) and InstRet <= InstRet + 1.
REQ-019 RUN, Stall=0, NextPCsrc=1, not misaligned: PC <= effective target and InstRet <= InstRet + 1.
REQ-020 RUN, Stall=0, misaligned: state <= TRAP, TrapPC <= PC, PC held, InstRet held.
REQ-021 TRAP, TrapClr=0: PC, InstRet and TrapPC SHALL hold. NextPCsrc, ALURes and Stall are ignored.
REQ-022 TRAP, TrapClr=1: state <= RUN, PC <= TRAP_VECTOR, InstRet held, TrapPC held. Stall does not block TrapClr.
REQ-023 TrapClr SHALL be ignored in RUN.
REQ-024 PC wrap: PC = 32'hFFFF_FFFC sequential step SHALL yield 32'h0000_0000, and PCplus4 SHALL likewise read 0.
REQ-025 InstRet SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-026 Latency: a PC decision sampled at edge N SHALL be visible on PC after edge N. There is no bubble cycle.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for a clock edge, force PC = RESET_VECTOR, state = RUN, Trap = 0, TrapPC = 0, InstRet = 0.
REQ-028 Reset asserted mid-operation, including in TRAP, SHALL override every input. The first update SHALL occur on the first rising edge with rst_n high.

Verification
REQ-029 Reset then 3 edges with Stall=0, NextPCsrc=0 -> PC = 0x0C, InstRet = 3, PCplus4 = 0x10.
REQ-030 PC = 0x0C, NextPCsrc=1, ALURes = 0x41 -> PC = 0x40 next edge, InstRet increments. Stall=1 with NextPCsrc=1, ALURes = 0x80 -> PC stays 0x40.
REQ-031 PC = 0x40, NextPCsrc=1, ALURes = 0x46 -> Trap = 1, TrapPC = 0x40, PC = 0x40, InstRet unchanged. Stimulus held for 2 edges -> no change. TrapClr=1 with Stall=1 -> Trap = 0, PC = 0x100.
REQ-032 Force PC to 0xFFFF_FFFC via a jump, then one sequential step -> PC = 0x0000_0000. PCplus4 reads 0 before the step.
REQ-033 rst_n pulsed low between clock edges while in TRAP -> PC = RESET_VECTOR, Trap = 0, InstRet = 0, all visible before the next clk edge.
